// File: rtl/uart_rx_pkt_ctrl_if.sv
// Byte-stream and packet-stream bundle for the UART packet receive controller.
// The slave modport is the controller's view; the master modport drives the
// receiver-side inputs and consumes the packet stream and status.
interface uart_rx_pkt_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       i_rx_data;
    logic             i_rx_data_valid;
    logic             i_rx_data_error;
    logic             i_rx_busy;
    logic [7:0]       o_m_data;
    logic             o_m_valid;
    logic             i_m_ready;
    logic             o_m_last;
    logic             o_drop;
    logic [1:0]       o_drop_reason;
    logic             o_overrun;
    logic [CNT_W-1:0] o_pkt_cnt;
    logic [CNT_W-1:0] o_drop_cnt;

    modport slave (
        input  i_rx_data,
        input  i_rx_data_valid,
        input  i_rx_data_error,
        input  i_rx_busy,
        input  i_m_ready,
        output o_m_data,
        output o_m_valid,
        output o_m_last,
        output o_drop,
        output o_drop_reason,
        output o_overrun,
        output o_pkt_cnt,
        output o_drop_cnt
    );

    modport master (
        output i_rx_data,
        output i_rx_data_valid,
        output i_rx_data_error,
        output i_rx_busy,
        output i_m_ready,
        input  o_m_data,
        input  o_m_valid,
        input  o_m_last,
        input  o_drop,
        input  o_drop_reason,
        input  o_overrun,
        input  o_pkt_cnt,
        input  o_drop_cnt
    );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet receive controller behind the UART byte receiver.
// Parses SOF, LEN, payload, CHK frames into a one-frame buffer and releases
// the payload on a ready/valid stream only once the whole frame has checked
// good. Bad or stalled frames are dropped with a reason code.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SOF_BYTE = 8'h7E,
    parameter int         MAX_LEN  = 16,
    parameter int         TIMEOUT  = 64,
    parameter int         CNT_W    = 16
) (
    input  logic              i_rx_clk,
    input  logic              i_rx_rst,
    uart_rx_pkt_ctrl_if.slave bus
);
    localparam int IDX_W  = $clog2(MAX_LEN + 1);
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] R_PARITY  = 2'd0;
    localparam logic [1:0] R_LENGTH  = 2'd1;
    localparam logic [1:0] R_CHKSUM  = 2'd2;
    localparam logic [1:0] R_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]       chk_q, chk_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             m_valid_q, m_valid_d;
    logic             drop_q, drop_d;
    logic [1:0]       reason_q, reason_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [7:0]       mem_q [MAX_LEN];
    logic             mem_we;

    logic             byte_ev;
    logic             timed;
    logic             timeout_hit;
    logic             drop_req;
    logic [1:0]       drop_code;
    logic             rd_last;

    // Frame parser, drain handshake, inter-byte timer and statistics next-state
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        chk_d       = chk_q;
        tmr_d       = tmr_q;
        m_valid_d   = m_valid_q;
        drop_d      = 1'b0;
        reason_d    = reason_q;
        overrun_d   = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        mem_we      = 1'b0;
        drop_req    = 1'b0;
        drop_code   = R_PARITY;

        byte_ev = bus.i_rx_data_valid;
        timed   = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
        rd_last = (rd_idx_q == len_q - IDX_ONE);

        if (!timed || byte_ev) begin
            tmr_d = '0;
        end else if (!bus.i_rx_busy) begin
            tmr_d = tmr_q + TMR_ONE;
        end
        timeout_hit = timed && !byte_ev && !bus.i_rx_busy && (tmr_q == TMR_LAST);

        case (state_q)
            S_IDLE: begin
                if (byte_ev && !bus.i_rx_data_error && bus.i_rx_data == SOF_BYTE) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (byte_ev) begin
                    if (bus.i_rx_data_error) begin
                        drop_req  = 1'b1;
                        drop_code = R_PARITY;
                    end else if (bus.i_rx_data == 8'd0 || bus.i_rx_data > 8'(MAX_LEN)) begin
                        drop_req  = 1'b1;
                        drop_code = R_LENGTH;
                    end else begin
                        len_d    = bus.i_rx_data[IDX_W-1:0];
                        chk_d    = bus.i_rx_data;
                        wr_idx_d = '0;
                        state_d  = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (byte_ev) begin
                    if (bus.i_rx_data_error) begin
                        drop_req  = 1'b1;
                        drop_code = R_PARITY;
                    end else begin
                        mem_we   = 1'b1;
                        chk_d    = chk_q ^ bus.i_rx_data;
                        wr_idx_d = wr_idx_q + IDX_ONE;
                        if (wr_idx_q == len_q - IDX_ONE) begin
                            state_d = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (byte_ev) begin
                    if (bus.i_rx_data_error) begin
                        drop_req  = 1'b1;
                        drop_code = R_PARITY;
                    end else if (bus.i_rx_data != chk_q) begin
                        drop_req  = 1'b1;
                        drop_code = R_CHKSUM;
                    end else begin
                        rd_idx_d  = '0;
                        m_valid_d = 1'b1;
                        state_d   = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (byte_ev) begin
                    overrun_d = 1'b1;
                end
                if (m_valid_q && bus.i_m_ready) begin
                    if (rd_last) begin
                        m_valid_d = 1'b0;
                        state_d   = S_IDLE;
                        if (pkt_cnt_q != '1) begin
                            pkt_cnt_d = pkt_cnt_q + CNT_ONE;
                        end
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_ONE;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                m_valid_d = 1'b0;
            end
        endcase

        if (timeout_hit) begin
            drop_req  = 1'b1;
            drop_code = R_TIMEOUT;
        end

        if (drop_req) begin
            state_d  = S_IDLE;
            drop_d   = 1'b1;
            reason_d = drop_code;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_ONE;
            end
        end
    end

    // Control state, pulses and counters; reset abandons any frame in flight
    always_ff @(posedge i_rx_clk or negedge i_rx_rst) begin
        if (!i_rx_rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            chk_q      <= '0;
            tmr_q      <= '0;
            m_valid_q  <= 1'b0;
            drop_q     <= 1'b0;
            reason_q   <= R_PARITY;
            overrun_q  <= 1'b0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            chk_q      <= chk_d;
            tmr_q      <= tmr_d;
            m_valid_q  <= m_valid_d;
            drop_q     <= drop_d;
            reason_q   <= reason_d;
            overrun_q  <= overrun_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Payload buffer; contents only matter once a frame has fully checked good
    always_ff @(posedge i_rx_clk) begin
        if (mem_we) begin
            mem_q[wr_idx_q[ADDR_W-1:0]] <= bus.i_rx_data;
        end
    end

    assign bus.o_m_data      = mem_q[rd_idx_q[ADDR_W-1:0]];
    assign bus.o_m_valid     = m_valid_q;
    assign bus.o_m_last      = m_valid_q && rd_last;
    assign bus.o_drop        = drop_q;
    assign bus.o_drop_reason = reason_q;
    assign bus.o_overrun     = overrun_q;
    assign bus.o_pkt_cnt     = pkt_cnt_q;
    assign bus.o_drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed testbench for uart_rx_pkt_ctrl: good frames, backpressure,
// overrun, length/checksum/parity drops, timeout and mid-frame reset.
module tb_uart_rx_pkt_ctrl;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   seen_drop;

    uart_rx_pkt_ctrl_if #(.CNT_W(CNT_W)) bus ();

    uart_rx_pkt_ctrl #(
        .SOF_BYTE (8'h7E),
        .MAX_LEN  (16),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (CNT_W)
    ) dut (
        .i_rx_clk (clk),
        .i_rx_rst (rst),
        .bus      (bus.slave)
    );

    // Free-running clock, rising edge active
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one received byte; called on a falling edge, returns on the next
    // falling edge so outputs reflect the rising edge that sampled the byte
    task automatic applyStimulus(input logic [7:0] data, input logic err);
        bus.i_rx_data       = data;
        bus.i_rx_data_error = err;
        bus.i_rx_data_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_data_valid = 1'b0;
        bus.i_rx_data_error = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Linear sequence of directed steps
    initial begin
        checks              = 0;
        errors              = 0;
        rst                 = 1'b0;
        bus.i_rx_data       = 8'h00;
        bus.i_rx_data_valid = 1'b0;
        bus.i_rx_data_error = 1'b0;
        bus.i_rx_busy       = 1'b0;
        bus.i_m_ready       = 1'b1;

        #1;
        checkOutput("rst_valid",   32'(bus.o_m_valid), 32'd0);
        checkOutput("rst_last",    32'(bus.o_m_last), 32'd0);
        checkOutput("rst_drop",    32'(bus.o_drop), 32'd0);
        checkOutput("rst_overrun", 32'(bus.o_overrun), 32'd0);
        checkOutput("rst_reason",  32'(bus.o_drop_reason), 32'd0);
        checkOutput("rst_pktcnt",  32'(bus.o_pkt_cnt), 32'd0);
        checkOutput("rst_dropcnt", 32'(bus.o_drop_cnt), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] good frame");
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h03, 1'b0);
        checkOutput("good_v0", 32'(bus.o_m_valid), 32'd1);
        checkOutput("good_d0", 32'(bus.o_m_data), 32'h11);
        checkOutput("good_l0", 32'(bus.o_m_last), 32'd0);
        checkOutput("good_nodrop", 32'(bus.o_drop), 32'd0);
        @(negedge clk);
        checkOutput("good_d1", 32'(bus.o_m_data), 32'h22);
        checkOutput("good_l1", 32'(bus.o_m_last), 32'd0);
        @(negedge clk);
        checkOutput("good_d2", 32'(bus.o_m_data), 32'h33);
        checkOutput("good_l2", 32'(bus.o_m_last), 32'd1);
        @(negedge clk);
        checkOutput("good_vend", 32'(bus.o_m_valid), 32'd0);
        checkOutput("good_pktcnt", 32'(bus.o_pkt_cnt), 32'd1);
        checkOutput("good_dropcnt", 32'(bus.o_drop_cnt), 32'd0);

        $display("[TB] backpressure and overrun");
        bus.i_m_ready = 1'b0;
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h03, 1'b0);
        checkOutput("bp_v0", 32'(bus.o_m_valid), 32'd1);
        checkOutput("bp_d0", 32'(bus.o_m_data), 32'h11);
        @(negedge clk);
        checkOutput("bp_hold0", 32'(bus.o_m_data), 32'h11);
        applyStimulus(8'h7E, 1'b0);
        checkOutput("bp_overrun", 32'(bus.o_overrun), 32'd1);
        checkOutput("bp_hold1", 32'(bus.o_m_data), 32'h11);
        @(negedge clk);
        checkOutput("bp_overrun_pulse", 32'(bus.o_overrun), 32'd0);
        checkOutput("bp_hold2", 32'(bus.o_m_valid), 32'd1);
        bus.i_m_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_d1", 32'(bus.o_m_data), 32'h22);
        bus.i_m_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_d1_hold", 32'(bus.o_m_data), 32'h22);
        checkOutput("bp_l1_hold", 32'(bus.o_m_last), 32'd0);
        bus.i_m_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_d2", 32'(bus.o_m_data), 32'h33);
        checkOutput("bp_l2", 32'(bus.o_m_last), 32'd1);
        bus.i_m_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_d2_hold", 32'(bus.o_m_data), 32'h33);
        checkOutput("bp_v2_hold", 32'(bus.o_m_valid), 32'd1);
        bus.i_m_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_vend", 32'(bus.o_m_valid), 32'd0);
        checkOutput("bp_pktcnt", 32'(bus.o_pkt_cnt), 32'd2);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h55, 1'b0);
        applyStimulus(8'h54, 1'b0);
        @(negedge clk);
        checkOutput("lost_sof_valid", 32'(bus.o_m_valid), 32'd0);
        checkOutput("lost_sof_drop", 32'(bus.o_drop_cnt), 32'd0);
        checkOutput("lost_sof_pktcnt", 32'(bus.o_pkt_cnt), 32'd2);

        $display("[TB] checksum and length drops");
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h04, 1'b0);
        checkOutput("chk_drop", 32'(bus.o_drop), 32'd1);
        checkOutput("chk_reason", 32'(bus.o_drop_reason), 32'd2);
        checkOutput("chk_novalid", 32'(bus.o_m_valid), 32'd0);
        @(negedge clk);
        checkOutput("chk_drop_pulse", 32'(bus.o_drop), 32'd0);
        checkOutput("chk_reason_held", 32'(bus.o_drop_reason), 32'd2);
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("len0_drop", 32'(bus.o_drop), 32'd1);
        checkOutput("len0_reason", 32'(bus.o_drop_reason), 32'd1);
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h11, 1'b0);
        checkOutput("len17_drop", 32'(bus.o_drop), 32'd1);
        checkOutput("len17_reason", 32'(bus.o_drop_reason), 32'd1);
        checkOutput("len_dropcnt", 32'(bus.o_drop_cnt), 32'd3);

        $display("[TB] parity errors");
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'hAA, 1'b1);
        checkOutput("par_drop", 32'(bus.o_drop), 32'd1);
        checkOutput("par_reason", 32'(bus.o_drop_reason), 32'd0);
        checkOutput("par_dropcnt", 32'(bus.o_drop_cnt), 32'd4);
        applyStimulus(8'h7E, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("par_sof_nodrop", 32'(bus.o_drop), 32'd0);
        checkOutput("par_sof_dropcnt", 32'(bus.o_drop_cnt), 32'd4);

        $display("[TB] timeout");
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'hAA, 1'b0);
        seen_drop = 1'b0;
        repeat (TIMEOUT - 1) begin
            @(negedge clk);
            if (bus.o_drop) seen_drop = 1'b1;
        end
        checkOutput("tmo_early", 32'(seen_drop), 32'd0);
        @(negedge clk);
        checkOutput("tmo_drop", 32'(bus.o_drop), 32'd1);
        checkOutput("tmo_reason", 32'(bus.o_drop_reason), 32'd3);
        checkOutput("tmo_dropcnt", 32'(bus.o_drop_cnt), 32'd5);

        $display("[TB] busy holds timer");
        bus.i_rx_busy = 1'b1;
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'hAA, 1'b0);
        seen_drop = 1'b0;
        repeat (TIMEOUT + 8) begin
            @(negedge clk);
            if (bus.o_drop) seen_drop = 1'b1;
        end
        checkOutput("busy_nodrop", 32'(seen_drop), 32'd0);
        bus.i_rx_busy = 1'b0;
        applyStimulus(8'hBB, 1'b0);
        applyStimulus(8'h13, 1'b0);
        checkOutput("busy_v0", 32'(bus.o_m_valid), 32'd1);
        checkOutput("busy_d0", 32'(bus.o_m_data), 32'hAA);
        @(negedge clk);
        checkOutput("busy_d1", 32'(bus.o_m_data), 32'hBB);
        checkOutput("busy_l1", 32'(bus.o_m_last), 32'd1);
        @(negedge clk);
        checkOutput("busy_pktcnt", 32'(bus.o_pkt_cnt), 32'd3);

        $display("[TB] byte on terminal timeout cycle");
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h01, 1'b0);
        seen_drop = 1'b0;
        repeat (TIMEOUT - 1) begin
            @(negedge clk);
            if (bus.o_drop) seen_drop = 1'b1;
        end
        applyStimulus(8'h5A, 1'b0);
        if (bus.o_drop) seen_drop = 1'b1;
        checkOutput("term_nodrop", 32'(seen_drop), 32'd0);
        applyStimulus(8'h5B, 1'b0);
        checkOutput("term_v0", 32'(bus.o_m_valid), 32'd1);
        checkOutput("term_d0", 32'(bus.o_m_data), 32'h5A);
        checkOutput("term_l0", 32'(bus.o_m_last), 32'd1);
        @(negedge clk);
        checkOutput("term_pktcnt", 32'(bus.o_pkt_cnt), 32'd4);
        checkOutput("term_dropcnt", 32'(bus.o_drop_cnt), 32'd5);

        $display("[TB] reset mid-payload");
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h11, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("rstp_valid", 32'(bus.o_m_valid), 32'd0);
        checkOutput("rstp_pktcnt", 32'(bus.o_pkt_cnt), 32'd0);
        checkOutput("rstp_dropcnt", 32'(bus.o_drop_cnt), 32'd0);
        checkOutput("rstp_reason", 32'(bus.o_drop_reason), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] reset mid-drain");
        bus.i_m_ready = 1'b0;
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h03, 1'b0);
        checkOutput("rstd_pre_valid", 32'(bus.o_m_valid), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("rstd_valid", 32'(bus.o_m_valid), 32'd0);
        checkOutput("rstd_last", 32'(bus.o_m_last), 32'd0);
        checkOutput("rstd_drop", 32'(bus.o_drop), 32'd0);
        checkOutput("rstd_overrun", 32'(bus.o_overrun), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.i_m_ready = 1'b1;
        @(negedge clk);
        applyStimulus(8'h7E, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h66, 1'b0);
        applyStimulus(8'h67, 1'b0);
        checkOutput("post_v0", 32'(bus.o_m_valid), 32'd1);
        checkOutput("post_d0", 32'(bus.o_m_data), 32'h66);
        checkOutput("post_l0", 32'(bus.o_m_last), 32'd1);
        @(negedge clk);
        checkOutput("post_vend", 32'(bus.o_m_valid), 32'd0);
        checkOutput("post_pktcnt", 32'(bus.o_pkt_cnt), 32'd1);
        checkOutput("post_dropcnt", 32'(bus.o_drop_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
